// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 UART receiver with ready/clear handshake and framing/overrun flags
module uart_cmd_rx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       ovr_err
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;
  state_t state, state_n;
  logic rx_q, rx_s, tick, good, bad;
  logic [CW-1:0] baud_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  assign tick = baud_cnt == '0;
  assign good = state == STOP && tick && rx_s;
  assign bad = state == STOP && tick && !rx_s;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = rx_s ? IDLE : START;
      START:   state_n = !tick ? START : rx_s ? IDLE : DATA;
      DATA:    state_n = (tick && bit_cnt == 3'd7) ? STOP : DATA;
      STOP:    state_n = !tick ? STOP : rx_s ? IDLE : WAIT_HI;
      WAIT_HI: state_n = rx_s ? IDLE : WAIT_HI;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q <= 1'b1;
      rx_s <= 1'b1;
      state <= IDLE;
      baud_cnt <= '0;
      bit_cnt <= '0;
      shift <= '0;
      rx_data <= '0;
      rdy <= 1'b0;
      frm_err <= 1'b0;
      ovr_err <= 1'b0;
    end else begin
      rx_q <= RX;
      rx_s <= rx_q;
      state <= state_n;
      // IDLE keeps the half-bit count armed so START samples mid start bit
      baud_cnt <= state == IDLE ? HALF : tick ? FULL : baud_cnt - 1'b1;
      if (state == START && tick)
        bit_cnt <= '0;
      else if (state == DATA && tick) begin
        shift <= {rx_s, shift[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      // a completing good frame wins over a coincident clr_rdy
      rdy <= good | (rdy & ~clr_rdy);
      ovr_err <= (good & rdy & ~clr_rdy) | (ovr_err & ~clr_rdy);
      if (good) begin
        rx_data <= shift;
        frm_err <= 1'b0;
      end else if (bad)
        frm_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: directed self-checking bench for uart_cmd_rx
module tb_uart_cmd_rx;
  localparam int B = 32;
  localparam int LAT = 2 + B / 2 + 9 * B;
  logic clk = 0, rst = 1, RX = 1, clr_rdy = 0;
  logic [7:0] rx_data;
  logic rdy, frm_err, ovr_err;
  int n = 0, errs = 0, rise;
  logic seen;

  uart_cmd_rx #(.BAUD_DIV(B)) dut (
    .clk(clk), .rst(rst), .RX(RX), .clr_rdy(clr_rdy),
    .rx_data(rx_data), .rdy(rdy), .frm_err(frm_err), .ovr_err(ovr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int k, input logic v);
    RX = v;
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_clr();
    clr_rdy = 1;
    @(posedge clk);
    #1;
    clr_rdy = 0;
  endtask

  task automatic frame(input logic [7:0] d, input logic stop, input int clr_at, input int rst_at, output int r);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    r = -1;
    for (int i = 0; i < 10 * B; i++) begin
      RX = bits[i / B];
      clr_rdy = (i == clr_at);
      rst = (i == rst_at);
      @(posedge clk);
      #1;
      if (r < 0 && rdy) r = i;
    end
    clr_rdy = 0;
    rst = 0;
  endtask

  initial begin
    repeat (5) @(posedge clk);
    #1;
    rst = 0;
    check("rst_data", 32'(rx_data), 32'h00);
    check("rst_rdy", 32'(rdy), 32'd0);
    check("rst_frm", 32'(frm_err), 32'd0);
    check("rst_ovr", 32'(ovr_err), 32'd0);
    seen = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      seen = seen | rdy | frm_err | ovr_err;
    end
    check("idle_quiet", 32'(seen), 32'd0);
    frame(8'h47, 1, -1, -1, rise);
    check("latency_ok", 32'(rise >= LAT - 1 && rise <= LAT + 1), 32'd1);
    check("g_rdy", 32'(rdy), 32'd1);
    check("g_data", 32'(rx_data), 32'h47);
    check("g_frm", 32'(frm_err), 32'd0);
    check("g_ovr", 32'(ovr_err), 32'd0);
    pulse_clr();
    check("clr_rdy", 32'(rdy), 32'd0);
    cyc(B / 4, 0);
    cyc(4 * B, 1);
    check("false_rdy", 32'(rdy), 32'd0);
    check("false_frm", 32'(frm_err), 32'd0);
    frame(8'h53, 1, -1, -1, rise);
    check("s_rdy", 32'(rdy), 32'd1);
    check("s_data", 32'(rx_data), 32'h53);
    pulse_clr();
    frame(8'h53, 0, -1, -1, rise);
    cyc(3 * B, 0);
    check("fe_frm", 32'(frm_err), 32'd1);
    check("fe_rdy", 32'(rdy), 32'd0);
    check("fe_data", 32'(rx_data), 32'h53);
    pulse_clr();
    check("fe_clr_keeps", 32'(frm_err), 32'd1);
    cyc(4 * B, 1);
    check("fe_no_retrig", 32'(rdy), 32'd0);
    frame(8'hC3, 0, -1, -1, rise);
    cyc(2 * B, 1);
    check("fe2_data", 32'(rx_data), 32'h53);
    check("fe2_frm", 32'(frm_err), 32'd1);
    check("fe2_rdy", 32'(rdy), 32'd0);
    frame(8'hA5, 1, -1, -1, rise);
    check("a5_frm", 32'(frm_err), 32'd0);
    check("a5_rdy", 32'(rdy), 32'd1);
    check("a5_data", 32'(rx_data), 32'hA5);
    pulse_clr();
    frame(8'h11, 1, -1, -1, rise);
    check("o11_ovr", 32'(ovr_err), 32'd0);
    frame(8'h22, 1, -1, -1, rise);
    check("ovr_data", 32'(rx_data), 32'h22);
    check("ovr_rdy", 32'(rdy), 32'd1);
    check("ovr_flag", 32'(ovr_err), 32'd1);
    pulse_clr();
    check("ovr_clr_rdy", 32'(rdy), 32'd0);
    check("ovr_clr_ovr", 32'(ovr_err), 32'd0);
    frame(8'h11, 1, -1, -1, rise);
    frame(8'h22, 1, LAT, -1, rise);
    check("coin_rdy", 32'(rdy), 32'd1);
    check("coin_ovr", 32'(ovr_err), 32'd0);
    check("coin_data", 32'(rx_data), 32'h22);
    frame(8'hFF, 1, -1, 5 * B + B / 2, rise);
    cyc(2 * B, 1);
    check("mr_rdy", 32'(rdy), 32'd0);
    check("mr_data", 32'(rx_data), 32'h00);
    check("mr_frm", 32'(frm_err), 32'd0);
    check("mr_ovr", 32'(ovr_err), 32'd0);
    frame(8'h3C, 1, -1, -1, rise);
    check("3c_rdy", 32'(rdy), 32'd1);
    check("3c_data", 32'(rx_data), 32'h3C);
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
